// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared Funct3 codes, FSM states and byte-enable constants for the LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H_LO = 4'b0011;
  localparam logic [3:0] BE_H_HI = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  // Lane enables by access size; H looks only at addr[1], W ignores the low bits.
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B, F3_BU: lane_be = BE_B << lo;
      F3_H, F3_HU: lane_be = lo[1] ? BE_H_HI : BE_H_LO;
      default:     lane_be = BE_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects and extends the loaded byte/half/word from a bus word,
// and flags accesses whose low address bits do not match the access size
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'd0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'd0, half_sel};
      F3_W:    result = rdata;
      default: result = 32'd0;
    endcase

    misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr_lo[0])
               || ((funct3 == F3_W) && (addr_lo != 2'd0));
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - load/store unit driving a req/gnt/rvalid data bus and stalling the core.
// Define MISALIGN_TRAP_EN to fail misaligned H/W accesses instead of ignoring the low address bits.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              LsuBusy,
  output logic              LsuDone,
  output logic              LsuErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 32 : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_MISALIGN = 1'b1;
`else
  localparam bit TRAP_MISALIGN = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]  al_lo;
  logic [2:0]  al_f3;
  logic [31:0] al_result;
  logic        al_misaligned;
  logic        bad_req;
  logic        timeout;

  // One aligner serves both the IDLE-time misalign check and the WAIT-time data capture.
  assign al_lo = (state_q == S_IDLE) ? ALUResult[1:0] : addr_q[1:0];
  assign al_f3 = (state_q == S_IDLE) ? Funct3 : f3_q;

  lsu_load_align u_align (
    .rdata      (mem_rdata),
    .addr_lo    (al_lo),
    .funct3     (al_f3),
    .result     (al_result),
    .misaligned (al_misaligned)
  );

  always_comb begin
    case (Funct3)
      F3_B, F3_H, F3_W: bad_req = MemRead & MemWrite;
      F3_BU, F3_HU:     bad_req = MemWrite;
      default:          bad_req = 1'b1;
    endcase
    if (TRAP_MISALIGN && al_misaligned) bad_req = 1'b1;
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q + 1'b1;
    mem_req = 1'b0;
    LsuBusy = 1'b0;
    LsuDone = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MemRead | MemWrite) begin
          LsuBusy = 1'b1;
          addr_d  = ALUResult;
          wdata_d = WriteData;
          f3_d    = Funct3;
          we_d    = MemWrite;
          rdata_d = 32'd0;
          cnt_d   = '0;
          err_d   = bad_req;
          state_d = bad_req ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        LsuBusy = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        LsuBusy = 1'b1;
        if (mem_rvalid) begin
          rdata_d = al_result;
          state_d = S_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        LsuDone = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      f3_q    <= 3'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // rdata_q is cleared on acceptance, so stores, errors and timeouts report zero.
  assign ReadData = (state_q == S_DONE) ? rdata_q : 32'd0;
  assign LsuErr   = (state_q == S_DONE) & err_q;
  assign mem_we   = mem_req & we_q;
  assign mem_addr = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be   = mem_req ? lane_be(f3_q, addr_q[1:0]) : 4'd0;

  always_comb begin
    mem_wdata = 32'd0;
    if (mem_req && we_q) begin
      case (f3_q)
        F3_B:    mem_wdata = {4{wdata_q[7:0]}};
        F3_H:    mem_wdata = {2{wdata_q[15:0]}};
        default: mem_wdata = wdata_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed self-checking bench for lsu_mem_stage (TIMEOUT_CYCLES=4)
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        LsuBusy, LsuDone, LsuErr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // results of the last access driven by run()
  logic        busy0, busy_all, stable, done_seen, we0, r_err;
  logic [31:0] a0, wd0, r_data;
  logic [3:0]  be0;
  int          req_cnt, lat;

  lsu_mem_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .LsuBusy(LsuBusy),
    .LsuDone(LsuDone), .LsuErr(LsuErr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one access from IDLE; gnt on REQ cycle gdly+1 (never if gdly<0), rvalid rdly cycles after gnt.
  task automatic run(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int gdly, input int rdly, input logic [31:0] rword);
    int n;
    int gnt_n;
    bit granted;
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = a; WriteData = wd; mem_rdata = rword;
    #1;
    busy0 = LsuBusy;
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
    n = 1; gnt_n = 0; granted = 1'b0;
    req_cnt = 0; busy_all = 1'b1; stable = 1'b1; done_seen = 1'b0; lat = 0;
    a0 = '0; be0 = '0; wd0 = '0; we0 = 1'b0; r_data = '0; r_err = 1'b0;
    while (n <= 20 && !done_seen) begin
      if (LsuDone) begin
        done_seen = 1'b1; lat = n; r_data = ReadData; r_err = LsuErr;
      end else begin
        if (!LsuBusy) busy_all = 1'b0;
        if (mem_req) begin
          req_cnt++;
          if (req_cnt == 1) begin
            a0 = mem_addr; be0 = mem_be; wd0 = mem_wdata; we0 = mem_we;
          end else if ({mem_addr, mem_be, mem_wdata} !== {a0, be0, wd0}) begin
            stable = 1'b0;
          end
        end
        mem_gnt    = mem_req && (gdly >= 0) && (req_cnt > gdly);
        mem_rvalid = granted && ((n - gnt_n) == rdly);
        if (mem_gnt) begin granted = 1'b1; gnt_n = n; end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        n++;
      end
    end
    check("done_within_bound", {31'd0, done_seen}, 32'd1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; MemRead = 0; MemWrite = 0; Funct3 = 0; ALUResult = 0; WriteData = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    tick();
    check("rst_req", mem_req, 0);
    check("rst_busy", LsuBusy, 0);
    check("rst_done", LsuDone, 0);
    check("rst_err", LsuErr, 0);
    check("rst_rdata", ReadData, 0);
    rst_n = 1'b1;
    tick();

    // SB at 0x1003
    run(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0);
    check("sb_busy_comb", busy0, 1);
    check("sb_addr", a0, 32'h0000_1000);
    check("sb_be", be0, 4'b1000);
    check("sb_wdata", wd0, 32'hA5A5_A5A5);
    check("sb_we", we0, 1);
    check("sb_lat", lat, 2);
    check("sb_err", r_err, 0);
    check("sb_rdata", r_data, 0);

    // SH upper half
    run(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 32'h0);
    check("sh_be", be0, 4'b1100);
    check("sh_wdata", wd0, 32'hABCD_ABCD);

    // LB / LBU at 0x2001
    run(1, 0, 3'b000, 32'h0000_2001, 32'h0, 0, 1, 32'h12F4_80FF);
    check("lb_data", r_data, 32'hFFFF_FF80);
    check("lb_be", be0, 4'b0010);
    check("lb_we", we0, 0);
    check("lb_lat", lat, 3);
    check("lb_err", r_err, 0);
    run(1, 0, 3'b100, 32'h0000_2001, 32'h0, 0, 1, 32'h12F4_80FF);
    check("lbu_data", r_data, 32'h0000_0080);

    // Halfword extraction
    run(1, 0, 3'b001, 32'h0000_2002, 32'h0, 0, 1, 32'h12F4_80FF);
    check("lh_hi_data", r_data, 32'h0000_12F4);
    run(1, 0, 3'b001, 32'h0000_2000, 32'h0, 0, 1, 32'h12F4_80FF);
    check("lh_lo_data", r_data, 32'hFFFF_80FF);
    run(1, 0, 3'b101, 32'h0000_2000, 32'h0, 0, 1, 32'h12F4_80FF);
    check("lhu_data", r_data, 32'h0000_80FF);

    // LW with stalled gnt and rvalid
    run(1, 0, 3'b010, 32'h0000_2000, 32'h0, 3, 2, 32'hDEAD_BEEF);
    check("lw_stall_reqcnt", req_cnt, 4);
    check("lw_stall_stable", stable, 1);
    check("lw_stall_busy", busy_all, 1);
    check("lw_stall_lat", lat, 7);
    check("lw_stall_data", r_data, 32'hDEAD_BEEF);
    check("lw_stall_err", r_err, 0);

    // Timeout: gnt never comes
    run(1, 0, 3'b010, 32'h0000_2000, 32'h0, -1, 1, 32'hDEAD_BEEF);
    check("to_reqcnt", req_cnt, 4);
    check("to_lat", lat, 5);
    check("to_err", r_err, 1);
    check("to_data", r_data, 0);

    // Misaligned word
    run(1, 0, 3'b010, 32'h0000_3002, 32'h0, 0, 1, 32'h5555_AAAA);
`ifdef MISALIGN_TRAP_EN
    check("lw_mis_reqcnt", req_cnt, 0);
    check("lw_mis_err", r_err, 1);
    check("lw_mis_data", r_data, 0);
`else
    check("lw_mis_addr", a0, 32'h0000_3000);
    check("lw_mis_err", r_err, 0);
    check("lw_mis_data", r_data, 32'h5555_AAAA);
`endif

    // Illegal requests never reach the bus
    run(1, 0, 3'b011, 32'h0000_2000, 32'h0, 0, 1, 32'h0);
    check("f3_011_reqcnt", req_cnt, 0);
    check("f3_011_err", r_err, 1);
    check("f3_011_lat", lat, 1);
    run(0, 1, 3'b100, 32'h0000_2000, 32'h0, 0, 1, 32'h0);
    check("sbu_err", r_err, 1);
    check("sbu_reqcnt", req_cnt, 0);
    run(1, 1, 3'b010, 32'h0000_2000, 32'h0, 0, 1, 32'h0);
    check("rdwr_err", r_err, 1);

    // Reset during REQ and during WAIT
    MemRead = 1; Funct3 = 3'b010; ALUResult = 32'h0000_4000;
    tick();
    MemRead = 0;
    check("rst_in_req_pre", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("rst_in_req_drop", mem_req, 0);
    check("rst_in_req_busy", LsuBusy, 0);
    #2 rst_n = 1'b1;
    tick();
    MemRead = 1;
    tick();
    MemRead = 0; mem_gnt = 1;
    tick();
    mem_gnt = 0;
    check("wait_busy_pre", LsuBusy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_in_wait_busy", LsuBusy, 0);
    check("rst_in_wait_req", mem_req, 0);
    #2 rst_n = 1'b1;
    mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rvalid = 0;
    check("late_rvalid_done", LsuDone, 0);
    tick();
    check("late_rvalid_done2", LsuDone, 0);
    check("late_rvalid_busy", LsuBusy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store unit directly downstream of the ALU. Takes ALUResult as the effective address and RegData2 as store data. Drives a req/gnt/rvalid data-memory bus with byte enables, then returns aligned, sign/zero-extended load data for writeback. Holds LsuBusy high to stall the core while a memory access is in flight.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ or WAIT before aborting with error; 0 disables the timeout
ADDR_W, 32, address width (ALUResult width)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
MemRead  in  1  load requested this instruction
MemWrite  in  1  store requested this instruction
Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResult  in  ADDR_W  effective byte address
WriteData  in  32  store data (RD2)
ReadData  out  32  extended load result, valid while LsuDone=1
LsuBusy  out  1  stall request to core
LsuDone  out  1  one-cycle completion pulse
LsuErr  out  1  error qualifier, valid with LsuDone
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low. Reset drives state to IDLE and all outputs to 0, including mem_req. Reset mid-transaction drops mem_req immediately; a late rvalid is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If MemRead|MemWrite: LsuBusy=1 combinationally in the same cycle. Latch address, data, Funct3 and direction; go to REQ.
  - MemRead&MemWrite together, or illegal Funct3 (011/110/111; for stores only 000/001/010 are legal): no bus request, go to DONE with LsuErr=1.
- Inputs are sampled only in IDLE. The core holds them stable while LsuBusy=1.
- REQ:
  - mem_req=1; addr/we/be/wdata held stable until mem_gnt.
  - On gnt: store goes to DONE, load goes to WAIT.
- WAIT: mem_rvalid is accepted no earlier than the cycle after gnt. On rvalid, capture the extended data and go to DONE.
- DONE: exactly one cycle. LsuDone=1, LsuBusy=0, ReadData valid (0 for stores and errors). Next state IDLE. Back-to-back accesses are possible: 1 idle-sample cycle per access.
- Latency:
  - Store with gnt in the first REQ cycle: LsuDone 2 cycles after acceptance.
  - Load with gnt and next-cycle rvalid: LsuDone 3 cycles after acceptance.
- Timeout: an 8-bit+ counter clears on entry to REQ or WAIT and increments each cycle. At TIMEOUT_CYCLES: drop mem_req, go to DONE with LsuErr=1 and ReadData=0.
- Store lanes:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{WriteData[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{WriteData[15:0]}}.
  - SW: be = 1111.
- Load extraction:
  - Byte select by addr[1:0]; half select by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Loads drive mem_be matching the access size (informational).

Optional Feature:
MISALIGN_TRAP_EN
- Defined: an H access with addr[0]=1, or a W access with addr[1:0]≠0, issues no bus request, goes to DONE with LsuErr=1, ReadData=0.
- Undefined: the offending low address bits are ignored (H uses addr[1] only, W ignores addr[1:0]) and the access proceeds normally.

Decomposition:
- lsu_pkg:
  - Funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding.
  - Byte-enable constants.
- Sub-module lsu_load_align: combinational rdata + addr[1:0] + Funct3 → extended 32-bit result. It is reused by the misalign logic and unit-tested standalone.

Test Plan:
- SB: WriteData=0x000000A5, addr 0x1003, gnt in first REQ cycle → mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, LsuDone after 2 cycles, LsuErr=0.
- LB and LBU at addr 0x2001 with mem_rdata=0x12F4_80FF:
  - LB → ReadData=0xFFFFFF80.
  - LBU → ReadData=0x00000080.
- LW with gnt delayed 3 cycles, rvalid 2 cycles later:
  - mem_req stays high with stable addr through the stall.
  - LsuBusy high throughout; ReadData=mem_rdata on the LsuDone cycle.
- TIMEOUT_CYCLES=4 with gnt never asserted → mem_req drops after 4 REQ cycles, LsuDone=1, LsuErr=1, ReadData=0.
- LW at 0x3002:
  - With MISALIGN_TRAP_EN: no mem_req, LsuErr=1.
  - Without: mem_addr=0x3000, LsuErr=0.
- rst_n pulsed low while in WAIT → mem_req/LsuBusy go to 0 immediately; a later rvalid produces no LsuDone; Funct3=011 load → LsuErr=1 with no bus activity.
